// File: rtl/fifo_buffer.sv
// Show-ahead synchronous FIFO with wrap-by-compare pointers (any depth >= 2).
// Define FIFO_BUFFER_STATUS_EN to add the count, overflow and underflow outputs.
module fifo_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
`ifdef FIFO_BUFFER_STATUS_EN
  ,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0] count,
  output logic                              overflow,
  output logic                              underflow
`endif
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_accept;
  logic                  rd_accept;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  // A push into a full queue is allowed when the same edge pops the head.
  assign wr_accept = din_valid && (!full || read_en);
  assign rd_accept = read_en && !empty;

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (wr_accept && !rd_accept) begin
      count_d = count_q + 1'b1;
    end else if (rd_accept && !wr_accept) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; reset only discards pointers and count.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

`ifdef FIFO_BUFFER_STATUS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (din_valid && full && !read_en);
    underflow_d = underflow_q || (read_en && empty && !din_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed testbench for fifo_buffer: a depth-4 instance for the main sequence
// and a depth-3 instance for pointer wrap on a non-power-of-two depth.
module tb_fifo_buffer;

  logic       clk;
  logic       rst;
  logic [7:0] din4, din3;
  logic       valid4, valid3;
  logic       rd4, rd3;
  logic [7:0] dout4, dout3;
  logic       empty4, empty3;
  logic       full4, full3;
`ifdef FIFO_BUFFER_STATUS_EN
  logic [2:0] count4;
  logic [1:0] count3;
  logic       ovf4, ovf3, unf4, unf3;
`endif

  int checkCount = 0;
  int passCount  = 0;

  fifo_buffer #(.DATA_WIDTH(8), .BUFFER_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(valid4), .read_en(rd4),
    .dout(dout4), .empty(empty4), .full(full4)
`ifdef FIFO_BUFFER_STATUS_EN
    , .count(count4), .overflow(ovf4), .underflow(unf4)
`endif
  );

  fifo_buffer #(.DATA_WIDTH(8), .BUFFER_DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .din_valid(valid3), .read_en(rd3),
    .dout(dout3), .empty(empty3), .full(full3)
`ifdef FIFO_BUFFER_STATUS_EN
    , .count(count3), .overflow(ovf3), .underflow(unf3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle on the depth-4 instance; outputs are sampled 1ns after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    valid4 = v;
    din4   = d;
    rd4    = r;
    @(posedge clk);
    #1;
    valid4 = 1'b0;
    rd4    = 1'b0;
  endtask

  task automatic applyStimulus3(input logic v, input logic [7:0] d, input logic r);
    valid3 = v;
    din3   = d;
    rd3    = r;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    rd3    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    valid4 = 1'b0; din4 = 8'h00; rd4 = 1'b0;
    valid3 = 1'b0; din3 = 8'h00; rd3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_empty", 32'(empty4), 32'h1);
    checkOutput("reset_full",  32'(full4),  32'h0);
    checkOutput("reset_dout",  32'(dout4),  32'h00);

    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("push1_dout",  32'(dout4),  32'h11);
    checkOutput("push1_empty", 32'(empty4), 32'h0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("push2_dout",  32'(dout4),  32'h11);
    applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("push3_full",  32'(full4),  32'h0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    checkOutput("push4_full",  32'(full4),  32'h1);
    checkOutput("push4_empty", 32'(empty4), 32'h0);

    applyStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("drop_full", 32'(full4), 32'h1);
    checkOutput("drop_dout", 32'(dout4), 32'h11);

    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pop1_dout", 32'(dout4), 32'h22);
    checkOutput("pop1_full", 32'(full4), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pop2_dout", 32'(dout4), 32'h33);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pop3_dout", 32'(dout4), 32'h44);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pop4_empty", 32'(empty4), 32'h1);
    checkOutput("pop4_dout",  32'(dout4),  32'h00);

    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    checkOutput("refill_full", 32'(full4), 32'h1);
    applyStimulus(1'b1, 8'h66, 1'b1);
    checkOutput("rw_full_full", 32'(full4), 32'h1);
    checkOutput("rw_full_dout", 32'(dout4), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rw_pop1_dout", 32'(dout4), 32'h33);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rw_pop2_dout", 32'(dout4), 32'h44);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rw_pop3_dout", 32'(dout4), 32'h66);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rw_drain_empty", 32'(empty4), 32'h1);

    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("under_empty", 32'(empty4), 32'h1);
    checkOutput("under_dout",  32'(dout4),  32'h00);
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("wr_rd_empty_empty", 32'(empty4), 32'h0);
    checkOutput("wr_rd_empty_dout",  32'(dout4),  32'h77);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("wr_rd_drain", 32'(empty4), 32'h1);

    // Wrap on depth 3: hold two entries and push+pop together ten times.
    applyStimulus3(1'b1, 8'h30, 1'b0);
    applyStimulus3(1'b1, 8'h31, 1'b0);
    checkOutput("wrap_prefill_dout", 32'(dout3), 32'h30);
    for (int i = 0; i < 10; i++) begin
      applyStimulus3(1'b1, 8'h32 + 8'(i), 1'b1);
      checkOutput($sformatf("wrap_cycle%0d_dout", i), 32'(dout3), 32'h31 + 32'(i));
      checkOutput($sformatf("wrap_cycle%0d_full", i), 32'(full3), 32'h0);
    end
    applyStimulus3(1'b1, 8'h3c, 1'b0);
    checkOutput("wrap_full", 32'(full3), 32'h1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("wrap_drain%0d_dout", i), 32'(dout3), 32'h3a + 32'(i));
      applyStimulus3(1'b0, 8'h00, 1'b1);
    end
    checkOutput("wrap_drain_empty", 32'(empty3), 32'h1);

    // Asynchronous reset mid-stream, checked well before the next rising edge.
    applyStimulus(1'b1, 8'h88, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0);
    checkOutput("pre_rst_dout", 32'(dout4), 32'h88);
    rst = 1'b1;
    #2;
    checkOutput("async_rst_empty", 32'(empty4), 32'h1);
    checkOutput("async_rst_dout",  32'(dout4),  32'h00);
    checkOutput("async_rst_full",  32'(full4),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 8'haa, 1'b0);
    checkOutput("post_rst_dout", 32'(dout4), 32'haa);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_rst_empty", 32'(empty4), 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
